cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between the three execution units: ALU, load/store and branch.
- Each cycle it picks at most one completed result, oldest in ROB order first, and registers it onto the CDB.
- The CDB feeds physical register file writeback, reservation station wakeup and ROB completion.
- Sits between the Issue/Execution stage and the Commit stage.

Parameters:
- ROB_WIDTH, 5, ROB index width (32-entry ROB).
- PHY_WIDTH, 6, physical register index width.
- DATA_WIDTH, 32, result data width.
- STARVE_LIMIT, 4, consecutive lost cycles after which a source is forced to win.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush  in  1  pipeline flush (mispredict recovery).
- rob_head  in  ROB_WIDTH  ROB index of the oldest in-flight instruction.
- cdb_stall  in  1  downstream cannot accept the CDB this cycle.
- alu_valid / ls_valid / br_valid  in  1 each  source has a result.
- alu_ready / ls_ready / br_ready  out  1 each  result accepted this cycle.
- alu_rob_id / ls_rob_id / br_rob_id  in  ROB_WIDTH each.
- alu_rd_phy / ls_rd_phy / br_rd_phy  in  PHY_WIDTH each.
- alu_data / ls_data / br_data  in  DATA_WIDTH each.
- alu_wr / ls_wr / br_wr  in  1 each  result writes a physical register. Stores and plain branches drive 0.
- cdb_valid  out  1  registered broadcast valid.
- cdb_rob_id  out  ROB_WIDTH.
- cdb_rd_phy  out  PHY_WIDTH.
- cdb_data  out  DATA_WIDTH.
- cdb_wr_en  out  1  equals cdb_valid & latched wr.
- cdb_src  out  2  winning source: 0=ALU, 1=LS, 2=BR.

Behaviour:
- Reset: rst_n is synchronous, active-low; one clock, all state on posedge clk. At reset, every cdb_* output is 0 and all starvation counters are 0. The *_ready outputs are combinational and are 0 during reset.
- accept = rst_n & ~flush & (~cdb_valid | ~cdb_stall).
- Arbitration (combinational, only when accept=1):
  - age_x = (x_rob_id - rob_head) mod 2^ROB_WIDTH.
  - If any valid source has starve_cnt == STARVE_LIMIT, grant among those by fixed priority BR > LS > ALU.
  - Otherwise grant the valid source with the smallest age. Equal ages resolve BR > LS > ALU.
  - Exactly one ready is asserted, for the grant. A transfer occurs when x_valid & x_ready.
- Latency: a result accepted in cycle N appears on cdb_* in cycle N+1.
- Output register:
  - Transfer: load the winning fields and set cdb_valid=1.
  - accept=1 with no valid source: cdb_valid <= 0.
  - cdb_valid=1 with cdb_stall=1: all cdb_* hold their values and all readies are 0.
- Starvation counters (one per source, saturating at STARVE_LIMIT):
  - Increment when the source is valid, accept=1 and it is not granted.
  - Clear when the source is granted or is not valid.
  - Hold while accept=0.
- flush:
  - Next cycle: cdb_valid <= 0, cdb_wr_en <= 0, all counters <= 0.
  - No ready is asserted during a flush cycle.
  - A flush during a stall drops the held result.
- Sources must hold valid and payload stable until ready, except across flush; the arbiter does not check this.
- ROB wrap: ages are modular, so rob_id=1 is younger than rob_id=30 when rob_head=28.
- Reset asserted mid-stall clears cdb_valid on the next edge, regardless of cdb_stall.

Test Plan:
- Reset, then rob_head=0; ALU rob 3 and LS rob 1 valid together -> ls_ready=1 in cycle N; next cycle cdb_src=1, cdb_rob_id=1. ALU then wins in N+1 and shows on the CDB in N+2.
- Wrap: rob_head=28, BR rob 1, ALU rob 30, all valid -> ALU granted first (age 2 < age 5).
- Stall: CDB holds rob 7 data 0xDEADBEEF with cdb_stall=1 for 3 cycles -> all readies 0 and outputs unchanged. Stall drops -> next source is accepted in the same cycle.
- Starvation, STARVE_LIMIT=4: ALU rob 10 valid and held while LS streams older IDs each cycle -> after 4 lost cycles ALU is granted in the 5th, despite LS being older.
- Flush while cdb_valid=1 and LS valid -> ls_ready=0 that cycle, cdb_valid=0 next cycle, counters 0.
- Store on LS with ls_wr=0 -> cdb_valid=1, cdb_wr_en=0. Branch with br_wr=1, rd_phy 12 -> cdb_wr_en=1, cdb_rd_phy=12.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks at most one finished result per cycle from
// the ALU, load/store and branch units (oldest in ROB order first) and registers it.
module cdb_arbiter #(
  parameter int ROB_WIDTH    = 5,
  parameter int PHY_WIDTH    = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [ROB_WIDTH-1:0]  rob_head,
  input  logic                  cdb_stall,

  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ROB_WIDTH-1:0]  alu_rob_id,
  input  logic [PHY_WIDTH-1:0]  alu_rd_phy,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  alu_wr,

  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [ROB_WIDTH-1:0]  ls_rob_id,
  input  logic [PHY_WIDTH-1:0]  ls_rd_phy,
  input  logic [DATA_WIDTH-1:0] ls_data,
  input  logic                  ls_wr,

  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [ROB_WIDTH-1:0]  br_rob_id,
  input  logic [PHY_WIDTH-1:0]  br_rd_phy,
  input  logic [DATA_WIDTH-1:0] br_data,
  input  logic                  br_wr,

  output logic                  cdb_valid,
  output logic [ROB_WIDTH-1:0]  cdb_rob_id,
  output logic [PHY_WIDTH-1:0]  cdb_rd_phy,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  cdb_wr_en,
  output logic [1:0]            cdb_src
);

  // Handshake: a source holds x_valid and its payload stable until it sees
  // x_ready; a transfer happens on a cycle where both are high. At most one
  // ready is high per cycle, and never while flushing, in reset, or while a
  // stalled result is still held on the bus.

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Source index: 0 = ALU, 1 = LS, 2 = BR (also the cdb_src encoding).
  logic [2:0]            valid;
  logic [2:0]            wr;
  logic [ROB_WIDTH-1:0]  rob_id   [3];
  logic [PHY_WIDTH-1:0]  rd_phy   [3];
  logic [DATA_WIDTH-1:0] data     [3];
  logic [ROB_WIDTH-1:0]  age      [3];
  logic [CW-1:0]         starve_cnt [3];
  logic [2:0]            starved;

  logic                  accept;
  logic [2:0]            grant;
  logic [1:0]            gnt_idx;
  logic                  gnt_any;
  logic [ROB_WIDTH-1:0]  best_age;

  assign valid     = {br_valid, ls_valid, alu_valid};
  assign wr        = {br_wr, ls_wr, alu_wr};
  assign rob_id[0] = alu_rob_id;
  assign rob_id[1] = ls_rob_id;
  assign rob_id[2] = br_rob_id;
  assign rd_phy[0] = alu_rd_phy;
  assign rd_phy[1] = ls_rd_phy;
  assign rd_phy[2] = br_rd_phy;
  assign data[0]   = alu_data;
  assign data[1]   = ls_data;
  assign data[2]   = br_data;

  assign accept = rst_n & ~flush & (~cdb_valid | ~cdb_stall);

  // Modular distance from the ROB head, so IDs that wrapped past 0 stay younger.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      age[i]     = rob_id[i] - rob_head;
      starved[i] = valid[i] && (starve_cnt[i] == LIMIT);
    end
  end

  // Starved sources override age; otherwise oldest wins. Scanning BR first
  // with a strict compare makes equal ages resolve BR > LS > ALU.
  always_comb begin
    grant    = '0;
    gnt_idx  = 2'd0;
    gnt_any  = 1'b0;
    best_age = '0;
    if (|starved) begin
      gnt_any = 1'b1;
      if (starved[2])      gnt_idx = 2'd2;
      else if (starved[1]) gnt_idx = 2'd1;
      else                 gnt_idx = 2'd0;
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (valid[i] && (!gnt_any || (age[i] < best_age))) begin
          gnt_any  = 1'b1;
          gnt_idx  = 2'(i);
          best_age = age[i];
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign alu_ready = accept & grant[0];
  assign ls_ready  = accept & grant[1];
  assign br_ready  = accept & grant[2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || flush) begin
        starve_cnt[i] <= '0;
      end else if (accept) begin
        if (!valid[i] || grant[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != LIMIT) begin
          starve_cnt[i] <= starve_cnt[i] + CW'(1);
        end
      end
    end
  end

  // When accept is low and no flush/reset, every cdb_* field holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_rd_phy <= '0;
      cdb_data   <= '0;
      cdb_wr_en  <= 1'b0;
      cdb_src    <= 2'd0;
    end else if (flush) begin
      cdb_valid  <= 1'b0;
      cdb_wr_en  <= 1'b0;
    end else if (accept) begin
      if (gnt_any) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= rob_id[gnt_idx];
        cdb_rd_phy <= rd_phy[gnt_idx];
        cdb_data   <= data[gnt_idx];
        cdb_wr_en  <= wr[gnt_idx];
        cdb_src    <= gnt_idx;
      end else begin
        cdb_valid  <= 1'b0;
        cdb_wr_en  <= 1'b0;
      end
    end
  end

endmodule
